// File: rtl/mips_multicycle_control.sv
// ============================================================================
// mips_multicycle_control : Moore control FSM for the multicycle MIPS datapath
// Revision 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_control #(
  parameter int CNT_W    = 32,
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             ula_zero_flag,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             ula_src_a,
  output logic [1:0]       ula_src_b,
  output logic [1:0]       ula_operation,
  output logic             instr_retired,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_addi  = 6'h08;

  typedef enum logic [3:0] {
    S_START     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_RD    = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WR    = 4'd8,
    S_BEQ       = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_pc_write;
  logic             w_pc_write_cond;
  logic             w_stall;

  assign w_stall     = MEM_WAIT && !mem_ready;
  assign pc_en       = w_pc_write | (w_pc_write_cond & ula_zero_flag);
  assign instr_count = r_instr_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_START;
      r_instr_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (instr_retired) begin
        r_instr_count <= r_instr_count + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next    = S_START;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    pc_source       = 2'b00;
    ir_write        = 1'b0;
    i_or_d          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_to_reg      = 1'b0;
    reg_dst         = 1'b0;
    reg_write       = 1'b0;
    ula_src_a       = 1'b0;
    ula_src_b       = 2'b00;
    ula_operation   = 2'b00;
    instr_retired   = 1'b0;
    illegal_op      = 1'b0;

    case (r_state)
      S_START: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        ir_write     = 1'b1;
        ula_src_b    = 2'b01;
        w_pc_write   = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here so BEQ only needs the compare cycle.
        ula_src_b = 2'b11;
        case (opcode)
          c_op_rtype: w_state_next = S_R_EXEC;
          c_op_lw,
          c_op_sw:    w_state_next = S_MEM_ADDR;
          c_op_beq:   w_state_next = S_BEQ;
          c_op_j:     w_state_next = S_JUMP;
          c_op_addi:  w_state_next = S_ADDI_EXEC;
          default: begin
            illegal_op   = 1'b1;
            w_state_next = S_FETCH;
          end
        endcase
      end
      S_R_EXEC: begin
        ula_src_a     = 1'b1;
        ula_operation = 2'b10;
        w_state_next  = S_R_WB;
      end
      S_R_WB: begin
        reg_dst       = 1'b1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ula_src_a    = 1'b1;
        ula_src_b    = 2'b10;
        w_state_next = (opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read     = 1'b1;
        i_or_d       = 1'b1;
        w_state_next = w_stall ? S_MEM_RD : S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg    = 1'b1;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write     = 1'b1;
        i_or_d        = 1'b1;
        instr_retired = !w_stall;
        w_state_next  = w_stall ? S_MEM_WR : S_FETCH;
      end
      S_BEQ: begin
        ula_src_a       = 1'b1;
        ula_operation   = 2'b01;
        w_pc_write_cond = 1'b1;
        pc_source       = 2'b01;
        instr_retired   = 1'b1;
        w_state_next    = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write    = 1'b1;
        pc_source     = 2'b10;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end
      S_ADDI_EXEC: begin
        ula_src_a    = 1'b1;
        ula_src_b    = 2'b10;
        w_state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        w_state_next  = S_FETCH;
      end
      default: begin
        w_state_next = S_START;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: random instruction stream vs. an
// instruction-level latency/output model; second instance checks the 4-bit counter wrap.
`default_nettype none

module tb_mips_multicycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       ula_zero_flag = 1'b0;
  logic       mem_ready = 1'b1;

  logic        pc_en, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst, reg_write;
  logic        ula_src_a, instr_retired, illegal_op;
  logic [1:0]  pc_source, ula_src_b, ula_operation;
  logic [31:0] instr_count;

  logic        pc_en_b, ir_write_b, i_or_d_b, mem_read_b, mem_write_b, mem_to_reg_b, reg_dst_b;
  logic        reg_write_b, ula_src_a_b, instr_retired_b, illegal_op_b;
  logic [1:0]  pc_source_b, ula_src_b_b, ula_operation_b;
  logic [3:0]  instr_count_b;

  mips_multicycle_control #(.CNT_W(32), .MEM_WAIT(1'b1)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .ula_zero_flag(ula_zero_flag),
    .mem_ready(mem_ready), .pc_en(pc_en), .pc_source(pc_source), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .ula_src_a(ula_src_a), .ula_src_b(ula_src_b),
    .ula_operation(ula_operation), .instr_retired(instr_retired), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  mips_multicycle_control #(.CNT_W(4), .MEM_WAIT(1'b1)) dut_w4 (
    .clock(clock), .reset(reset), .opcode(opcode), .ula_zero_flag(ula_zero_flag),
    .mem_ready(mem_ready), .pc_en(pc_en_b), .pc_source(pc_source_b), .ir_write(ir_write_b),
    .i_or_d(i_or_d_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b),
    .reg_dst(reg_dst_b), .reg_write(reg_write_b), .ula_src_a(ula_src_a_b), .ula_src_b(ula_src_b_b),
    .ula_operation(ula_operation_b), .instr_retired(instr_retired_b), .illegal_op(illegal_op_b),
    .instr_count(instr_count_b)
  );

  always #5 clock = ~clock;

  logic [16:0] outs;
  assign outs = {pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                 reg_write, ula_src_a, ula_src_b, ula_operation, instr_retired, illegal_op};

  // fin: {reg_write, reg_dst, mem_to_reg, mem_write, mem_read, i_or_d, pc_en, pc_source, ula_op}
  // prev: {ula_op, ula_src_b, mem_read} of the cycle before the final one
  typedef struct packed {
    logic        ill;
    logic [7:0]  lat;
    logic [10:0] fin;
    logic [4:0]  prev;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_count = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  prev_s = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic z, input int w);
    exp_t r;
    r = '0;
    case (op)
      6'h00: begin r.lat = 8'd4; r.fin = {3'b110, 3'b000, 1'b0, 2'b00, 2'b00}; r.prev = {2'b10, 2'b00, 1'b0}; end
      6'h23: begin r.lat = 8'(5 + w); r.fin = {3'b101, 3'b000, 1'b0, 2'b00, 2'b00}; r.prev = {2'b00, 2'b00, 1'b1}; end
      6'h2B: begin
        r.lat  = 8'(4 + w);
        r.fin  = {3'b000, 3'b101, 1'b0, 2'b00, 2'b00};
        r.prev = (w > 0) ? {2'b00, 2'b00, 1'b0} : {2'b00, 2'b10, 1'b0};
      end
      6'h04: begin r.lat = 8'd3; r.fin = {3'b000, 3'b000, z, 2'b01, 2'b01}; r.prev = {2'b00, 2'b11, 1'b0}; end
      6'h02: begin r.lat = 8'd3; r.fin = {3'b000, 3'b000, 1'b1, 2'b10, 2'b00}; r.prev = {2'b00, 2'b11, 1'b0}; end
      6'h08: begin r.lat = 8'd4; r.fin = {3'b100, 3'b000, 1'b0, 2'b00, 2'b00}; r.prev = {2'b00, 2'b10, 1'b0}; end
      default: begin r.ill = 1'b1; r.lat = 8'd2; r.fin = '0; r.prev = {2'b00, 2'b01, 1'b0}; end
    endcase
    return r;
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      cyc = ir_write ? 0 : cyc + 1;
      chk("strobes_exclusive", 32'($countones({mem_read, mem_write, reg_write}) <= 1), 32'd1);
      if (instr_retired || illegal_op) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("illegal_op", 32'(illegal_op), 32'(e.ill));
          chk("instr_retired", 32'(instr_retired), 32'(!e.ill));
          chk("latency", 32'(cyc + 1), 32'(e.lat));
          chk("final_outputs", {21'b0, reg_write, reg_dst, mem_to_reg, mem_write, mem_read, i_or_d,
                                pc_en, pc_source, ula_operation}, 32'(e.fin));
          chk("prev_cycle_outputs", 32'(prev_s), 32'(e.prev));
          chk("instr_count", instr_count, exp_count);
          chk("instr_count_w4", 32'(instr_count_b), 32'(exp_count[3:0]));
          if (!e.ill) exp_count = exp_count + 1;
        end
      end
      prev_s = {ula_operation, ula_src_b, mem_read};
    end
  end

  // Called at the negedge of a FETCH cycle; returns at the negedge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic z, input int w);
    int  c;
    bit  done;
    q.push_back(model(op, z, w));
    opcode = op;
    ula_zero_flag = z;
    mem_ready = 1'b1;
    c = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clock);
      #1;
      c++;
      mem_ready = !(c >= 3 && c < 3 + w);
      @(negedge clock);
      if (ir_write) done = 1'b1;
    end
    if (!done) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [5:0] op;
    int         w;

    #12;
    chk("reset_outputs", 32'(outs), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    chk("start_outputs", 32'(outs), 32'd0);
    @(negedge clock);
    chk("fetch_ir_write", 32'(ir_write), 32'd1);
    chk("fetch_pc_en", 32'(pc_en), 32'd1);
    cyc = 0;
    mon_en = 1'b1;

    repeat (16) run_instr(6'h02, 1'($urandom_range(0, 1)), 0);
    chk("wrap_count_w4", 32'(instr_count_b), 32'd0);
    chk("count_after_16", instr_count, 32'd16);

    run_instr(6'h00, 1'b0, 0);
    run_instr(6'h23, 1'b0, 2);
    run_instr(6'h04, 1'b1, 0);
    run_instr(6'h04, 1'b0, 0);
    run_instr(6'h3F, 1'b0, 0);
    run_instr(6'h2B, 1'b1, 1);
    run_instr(6'h08, 1'b0, 0);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h02;
        5: op = 6'h08;
        default: begin
          op = 6'($urandom);
          if (op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08}) op = 6'h3F;
        end
      endcase
      w = (op == 6'h23 || op == 6'h2B) ? int'($urandom_range(0, 3)) : 0;
      run_instr(op, 1'($urandom_range(0, 1)), w);
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_count", instr_count, exp_count);

    mon_en = 1'b0;
    opcode = 6'h2B;
    mem_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("in_mem_wr", 32'(mem_write), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_outputs", 32'(outs), 32'd0);
    chk("abort_count", instr_count, 32'd0);
    @(posedge clock); #1; reset = 1'b0; mem_ready = 1'b1;
    @(negedge clock);
    chk("restart_start", 32'(outs), 32'd0);
    @(negedge clock);
    chk("restart_fetch", {30'b0, ir_write, pc_en}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
